simple_unpacker: RTL and testbench
==================================

# simple_unpacker

Downstream stage for a wide single-entry access-enable buffer. The unpacker pulls one WIDTH_IN-bit word from the buffer's read interface and presents it as RATIO consecutive WIDTH_OUT-bit slices on its own access-enable read interface, least-significant slice first. It fetches the next word in the same cycle the last slice is consumed, so a continuous stream runs with no bubble.

## Interface

Parameters:
- WIDTH_IN, 32, upstream word width; must be an integer multiple of WIDTH_OUT.
- WIDTH_OUT, 8, downstream slice width.
- RATIO, derived localparam = WIDTH_IN/WIDTH_OUT. The index counter is max(1, clog2(RATIO)) bits wide.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- upstream_read_enable  out  1  pops one word from the upstream buffer this cycle.
- upstream_read_data  in  WIDTH_IN  upstream word, valid when upstream_empty is low.
- upstream_empty  in  1  upstream holds no word.
- read_enable  in  1  downstream consumes the current slice this cycle.
- read_data  out  WIDTH_OUT  current slice.
- empty  out  1  no slice available.
- last  out  1  present only with SIMPLE_UNPACKER_LAST_EN; current slice is the final slice of its word.

## Operation

- State: word register (WIDTH_IN bits), word_valid, slice index.
- empty = ~word_valid.
- read_data = word[index*WIDTH_OUT +: WIDTH_OUT].
- upstream_read_enable = ~reset & ~upstream_empty & (~word_valid | (read_enable & index==RATIO-1)).
- Priority on each clock edge:
  - reset: word=0, word_valid=0, index=0.
  - else if upstream_read_enable: word<=upstream_read_data, word_valid<=1, index<=0. This covers the refill and the last-slice-plus-refill cases.
  - else if read_enable & word_valid: if index==RATIO-1, set word_valid<=0 and index<=0; otherwise index<=index+1.
  - else: hold.
- read_enable while empty is ignored, with no state change. This is a safety the buffer itself lacks.
- A pop is issued only when upstream_empty is low, so the upstream buffer is never read while empty.
- RATIO=1: the block degenerates to a one-entry pass-through register with the same rules.

## Timing

- Reset values: empty=1, read_data=0, upstream_read_enable=0, index=0, last=0 (when built).
- upstream_read_enable is combinational from read_enable, upstream_empty and state. There is no combinational path from upstream_read_data to any output.
- Latency: upstream word available (upstream_empty=0) at cycle t while the unpacker is empty. The pop happens at t and slice 0 appears with empty=0 at t+1.
- Throughput: one slice per cycle when read_enable is held high. Back-to-back words produce no idle cycle, because the pop coincides with consuming slice RATIO-1.
- A word is held indefinitely while read_enable is low. The index advances only on a consumed slice.
- Reset asserted mid-word: the partial word is discarded and the next cycle shows empty=1. No pop is issued during the reset cycle.

## Configuration

- SIMPLE_UNPACKER_LAST_EN defined: adds output port last = word_valid & (index==RATIO-1), for framing the downstream consumer.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan

All scenarios use WIDTH_IN=32 and WIDTH_OUT=8 unless stated.

- Reset: hold reset 2 cycles with upstream_empty=0 -> upstream_read_enable=0 throughout, then empty=1 and read_data=0 after reset.
- Single word: upstream word 0xDDCCBBAA, read_enable held high -> slices 0xAA, 0xBB, 0xCC, 0xDD on 4 consecutive cycles, then empty=1. With the macro, last is high only on the 0xDD slice.
- Streaming: upstream supplies 0x03020100 then 0x07060504 back-to-back, read_enable always high -> slices 0x00 through 0x07 on 8 consecutive cycles. The second pop coincides with the 0x03 read.
- Stall: read_enable toggles 1,0,0,1,1,1 -> index and read_data hold during the low cycles, and all 4 slices are delivered in order.
- Empty read: read_enable=1 with upstream_empty=1 and the unpacker empty -> no state change, empty stays 1, upstream_read_enable=0.
- Mid-word reset: reset asserted after slice 1 of 0x44332211 -> empty=1 next cycle. After reset releases, a new word 0x88776655 delivers 0x55 first.

Source files
------------

// File: rtl/simple_unpacker.sv
// Width-down unpacker: pops one WIDTH_IN word from an upstream access-enable buffer
// and serves it as WIDTH_IN/WIDTH_OUT slices, LSB slice first. Optional `last` output
// under macro SIMPLE_UNPACKER_LAST_EN.
module simple_unpacker #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 upstream_read_enable,
  input  logic [WIDTH_IN-1:0]  upstream_read_data,
  input  logic                 upstream_empty,
  input  logic                 read_enable,
  output logic [WIDTH_OUT-1:0] read_data,
`ifdef SIMPLE_UNPACKER_LAST_EN
  output logic                 last,
`endif
  output logic                 empty
);

  localparam int RATIO = WIDTH_IN / WIDTH_OUT;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  logic [WIDTH_IN-1:0] word_p0;
  logic                vld_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic                at_last;

  assign at_last = (idx_p0 == IDX_LAST);

  // Refill whenever empty, or in the same cycle the final slice leaves, so streams run gap-free.
  assign upstream_read_enable = ~reset & ~upstream_empty & (~vld_p0 | (read_enable & at_last));

  // stage p0: word register, valid flag and slice index
  always_ff @(posedge clock) begin
    if (reset) begin
      word_p0 <= '0;
      vld_p0  <= 1'b0;
      idx_p0  <= '0;
    end else if (upstream_read_enable) begin
      word_p0 <= upstream_read_data;
      vld_p0  <= 1'b1;
      idx_p0  <= '0;
    end else if (read_enable & vld_p0) begin
      if (at_last) begin
        vld_p0 <= 1'b0;
        idx_p0 <= '0;
      end else begin
        idx_p0 <= idx_p0 + 1'b1;
      end
    end
  end

  assign empty     = ~vld_p0;
  assign read_data = word_p0[int'(idx_p0)*WIDTH_OUT +: WIDTH_OUT];

`ifdef SIMPLE_UNPACKER_LAST_EN
  assign last = vld_p0 & at_last;
`endif

endmodule

// File: tb/tb_simple_unpacker.sv
// Scoreboard bench for simple_unpacker (32 -> 8): expected slices are queued when words
// are offered upstream; a negedge monitor pops and compares each consumed slice.
module tb_simple_unpacker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        upstream_read_enable;
  logic [31:0] upstream_read_data = '0;
  logic        upstream_empty = 1'b1;
  logic        read_enable = 1'b0;
  logic [7:0]  read_data;
  logic        empty;
`ifdef SIMPLE_UNPACKER_LAST_EN
  logic        last;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       lst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] up_q[$];
  int          checks = 0;
  int          errors = 0;

  simple_unpacker #(.WIDTH_IN(32), .WIDTH_OUT(8)) dut (
    .clock                (clock),
    .reset                (reset),
    .upstream_read_enable (upstream_read_enable),
    .upstream_read_data   (upstream_read_data),
    .upstream_empty       (upstream_empty),
    .read_enable          (read_enable),
    .read_data            (read_data),
`ifdef SIMPLE_UNPACKER_LAST_EN
    .last                 (last),
`endif
    .empty                (empty)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic refresh_upstream();
    upstream_empty     = (up_q.size() == 0);
    upstream_read_data = (up_q.size() == 0) ? 32'h0 : up_q[0];
  endtask

  // Offer a word upstream and queue its four slices as expectations.
  task automatic offer(input logic [31:0] w, input int n_expected);
    up_q.push_back(w);
    for (int i = 0; i < n_expected; i++) begin
      exp_t e;
      e.data = w[i*8 +: 8];
      e.lst  = (i == 3);
      exp_q.push_back(e);
    end
    refresh_upstream();
  endtask

  // One clock: capture the pop request before the edge, apply it after.
  task automatic tick();
    logic pop;
    @(negedge clock);
    pop = upstream_read_enable;
    @(posedge clock);
    #1;
    if (pop) begin
      if (up_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_while_empty: got pop=1, expected pop=0");
      end else begin
        void'(up_q.pop_front());
      end
    end
    refresh_upstream();
  endtask

  // Monitor: every consumed slice must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && !empty && read_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL slice_unexpected: got %h, expected no slice", read_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (read_data !== e.data) begin
          errors++;
          $display("FAIL slice_data: got %h, expected %h", read_data, e.data);
        end
`ifdef SIMPLE_UNPACKER_LAST_EN
        checks++;
        if (last !== e.lst) begin
          errors++;
          $display("FAIL slice_last: got %b, expected %b for data %h", last, e.lst, e.data);
        end
`endif
      end
    end
  end

  initial begin
    // Reset held two cycles with a word waiting upstream
    read_enable = 1'b1;
    offer(32'hDDCCBBAA, 4);
    for (int i = 0; i < 2; i++) begin
      #1 check("reset_no_pop", upstream_read_enable, 0);
      tick();
    end
    check("reset_empty", empty, 1);
    check("reset_read_data", read_data, 0);
`ifdef SIMPLE_UNPACKER_LAST_EN
    check("reset_last", last, 0);
`endif
    reset = 1'b0;

    // Single word, read_enable held high
    #1 check("single_pop", upstream_read_enable, 1);
    tick();
    check("single_first", read_data, 32'hAA);
    for (int i = 0; i < 4; i++) tick();
    check("single_drained", empty, 1);
    check("single_no_pop", upstream_read_enable, 0);

    // Streaming two words back-to-back
    offer(32'h03020100, 4);
    offer(32'h07060504, 4);
    #1 check("stream_first_pop", upstream_read_enable, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", empty, 0);
      if (i == 3) check("stream_refill_pop", upstream_read_enable, 1);
      if (i == 7) check("stream_final_no_pop", upstream_read_enable, 0);
      tick();
    end
    check("stream_drained", empty, 1);

    // Stall pattern 1,0,0,1,1,1
    read_enable = 1'b0;
    offer(32'hA3A2A1A0, 4);
    #1 check("stall_pop", upstream_read_enable, 1);
    tick();
    check("stall_slice0", read_data, 32'hA0);
    begin
      logic [5:0] pat;
      pat = 6'b111001;
      for (int i = 0; i < 6; i++) begin
        read_enable = pat[i];
        #1;
        if (!pat[i]) check("stall_hold", read_data, 32'hA1);
        tick();
      end
    end
    check("stall_drained", empty, 1);

    // Read while empty and nothing upstream
    read_enable = 1'b1;
    #1 check("emptyrd_no_pop", upstream_read_enable, 0);
    check("emptyrd_empty", empty, 1);
    tick();
    check("emptyrd_still_empty", empty, 1);

    // Mid-word reset after slice 1
    offer(32'h44332211, 2);
    tick();
    tick();
    tick();
    check("midrst_slice2_shown", read_data, 32'h33);
    offer(32'h88776655, 4);
    reset = 1'b1;
    #1 check("midrst_no_pop", upstream_read_enable, 0);
    tick();
    reset = 1'b0;
    #1 check("midrst_empty", empty, 1);
    check("midrst_refill_pop", upstream_read_enable, 1);
    tick();
    check("midrst_new_first", read_data, 32'h55);
    for (int i = 0; i < 4; i++) tick();
    check("midrst_drained", empty, 1);

    read_enable = 1'b0;
    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
